axicb_mst_arbiter: RTL and testbench

Registered, priority-aware round-robin arbiter that sequences one address channel (AW or AR) of the crossbar master switch among up to 4 masters. Holds each grant until the address handshake completes and limits per-master outstanding transactions. Optionally revokes a grant that stalls too long, so one blocked master cannot starve the others. Its one-hot grant drives the switch's address and data muxes directly.

---
 rtl/axicb_mst_arbiter_if.sv | 25 ++
 rtl/axicb_mst_arbiter.sv | 179 +++++++++++++++++
 tb/tb_axicb_mst_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_mst_arbiter_if.sv
// Address-channel arbitration bundle between the crossbar master switch and its arbiter.
// The switch side drives requests/handshakes; the arbiter side returns grant and status.
interface axicb_mst_arbiter_if #(
    parameter int REQ_NB = 4
);
    logic [REQ_NB-1:0]   req;
    logic                accept;
    logic [REQ_NB-1:0]   done;
    logic [REQ_NB-1:0]   grant;
    logic                busy;
    logic [REQ_NB*4-1:0] out_cnt;
    logic                timeout_pulse;
    logic [1:0]          timeout_idx;
    logic                cnt_err;

    modport master (
        output req, accept, done,
        input  grant, busy, out_cnt, timeout_pulse, timeout_idx, cnt_err
    );

    modport slave (
        input  req, accept, done,
        output grant, busy, out_cnt, timeout_pulse, timeout_idx, cnt_err
    );
endinterface

// File: rtl/axicb_mst_arbiter.sv
// Registered priority-aware round-robin arbiter for one AW/AR channel of the master switch,
// with per-master outstanding limits and optional revocation of stalled grants.
module axicb_mst_arbiter #(
    parameter int REQ_NB          = 4,
    parameter int REQ0_PRIORITY   = 0,
    parameter int REQ1_PRIORITY   = 0,
    parameter int REQ2_PRIORITY   = 0,
    parameter int REQ3_PRIORITY   = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_ENABLE  = 1,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    axicb_mst_arbiter_if.slave arb
);

    function automatic logic [1:0] clamp_prio(input int p);
        return (p > 3) ? 2'd3 : ((p < 0) ? 2'd0 : 2'(p));
    endfunction

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      CNT_MAX  = 4'(MAX_OUTSTANDING);
    localparam logic [1:0]      PTR_RST  = 2'(REQ_NB - 1);
    localparam logic [7:0]      PRIO     = {clamp_prio(REQ3_PRIORITY), clamp_prio(REQ2_PRIORITY),
                                            clamp_prio(REQ1_PRIORITY), clamp_prio(REQ0_PRIORITY)};

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    // Internals are always four masters wide; unused masters never request.
    logic [3:0]            req4;
    logic [3:0]            done4;
    state_t                state_p0, state_nxt;
    logic [3:0]            grant_p0, grant_nxt;
    logic [1:0]            gidx_p0, gidx_nxt;
    logic [1:0]            ptr_p0, ptr_nxt;
    logic [TMR_W-1:0]      timer_p0, timer_nxt;
    logic                  tmo_p0, tmo_nxt;
    logic [1:0]            tidx_p0, tidx_nxt;
    logic [3:0][3:0]       cnt_p0, cnt_nxt;
    logic                  err_p0, err_nxt;
    logic [3:0]            acc_inc;
    logic [3:0]            elig;
    logic [3:0]            cand;
    logic [1:0]            top_lvl;
    logic                  win_vld;
    logic [1:0]            win_idx;
    int                    j;

    assign req4  = 4'(arb.req);
    assign done4 = 4'(arb.done);

    // Winner: highest level among eligible masters, ties broken from ptr+1 upward.
    always_comb begin
        elig    = '0;
        cand    = '0;
        top_lvl = 2'd0;
        win_vld = 1'b0;
        win_idx = 2'd0;
        j       = 0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = req4[i] && (cnt_p0[i] < CNT_MAX);
            if (elig[i] && (PRIO[2*i +: 2] > top_lvl)) top_lvl = PRIO[2*i +: 2];
        end
        for (int i = 0; i < 4; i++) begin
            cand[i] = elig[i] && (PRIO[2*i +: 2] == top_lvl);
        end
        for (int k = 1; k <= REQ_NB; k++) begin
            j = int'(ptr_p0) + k;
            if (j >= REQ_NB) j = j - REQ_NB;
            if (!win_vld && cand[j[1:0]]) begin
                win_vld = 1'b1;
                win_idx = j[1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state_p0;
        grant_nxt = grant_p0;
        gidx_nxt  = gidx_p0;
        ptr_nxt   = ptr_p0;
        timer_nxt = timer_p0;
        tmo_nxt   = 1'b0;
        tidx_nxt  = tidx_p0;
        acc_inc   = '0;
        case (state_p0)
            S_IDLE: begin
                grant_nxt = '0;
                if (win_vld) begin
                    grant_nxt = 4'b0001 << win_idx;
                    gidx_nxt  = win_idx;
                    timer_nxt = '0;
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                timer_nxt = timer_p0 + 1'b1;
                if (arb.accept) begin
                    acc_inc   = grant_p0;
                    ptr_nxt   = gidx_p0;
                    grant_nxt = '0;
                    state_nxt = S_IDLE;
                end else if (!req4[gidx_p0]) begin
                    grant_nxt = '0;
                    state_nxt = S_IDLE;
                end else if ((TIMEOUT_ENABLE != 0) && (timer_p0 == TMR_LAST)) begin
                    tmo_nxt   = 1'b1;
                    tidx_nxt  = gidx_p0;
                    ptr_nxt   = gidx_p0;
                    grant_nxt = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A same-cycle accept and done for one master cancel; done at zero flags an error.
    always_comb begin
        cnt_nxt = cnt_p0;
        err_nxt = err_p0;
        for (int i = 0; i < 4; i++) begin
            if (acc_inc[i] && !done4[i]) begin
                if (cnt_p0[i] < CNT_MAX) cnt_nxt[i] = cnt_p0[i] + 4'd1;
            end else if (done4[i] && !acc_inc[i]) begin
                if (cnt_p0[i] == 4'd0) err_nxt = 1'b1;
                else                   cnt_nxt[i] = cnt_p0[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_p0 <= S_IDLE;
            grant_p0 <= '0;
            gidx_p0  <= 2'd0;
            ptr_p0   <= PTR_RST;
            timer_p0 <= '0;
            tmo_p0   <= 1'b0;
            tidx_p0  <= 2'd0;
            cnt_p0   <= '0;
            err_p0   <= 1'b0;
        end else if (srst) begin
            state_p0 <= S_IDLE;
            grant_p0 <= '0;
            gidx_p0  <= 2'd0;
            ptr_p0   <= PTR_RST;
            timer_p0 <= '0;
            tmo_p0   <= 1'b0;
            tidx_p0  <= 2'd0;
            cnt_p0   <= '0;
            err_p0   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            grant_p0 <= grant_nxt;
            gidx_p0  <= gidx_nxt;
            ptr_p0   <= ptr_nxt;
            timer_p0 <= timer_nxt;
            tmo_p0   <= tmo_nxt;
            tidx_p0  <= tidx_nxt;
            cnt_p0   <= cnt_nxt;
            err_p0   <= err_nxt;
        end
    end

    assign arb.grant         = grant_p0[REQ_NB-1:0];
    assign arb.busy          = (state_p0 == S_GRANT);
    assign arb.out_cnt       = cnt_p0[REQ_NB-1:0];
    assign arb.timeout_pulse = tmo_p0;
    assign arb.timeout_idx   = tidx_p0;
    assign arb.cnt_err       = err_p0;

endmodule

// File: tb/tb_axicb_mst_arbiter.sv
// Bench for axicb_mst_arbiter: a cycle model fills a scoreboard that a monitor drains,
// with directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_axicb_mst_arbiter;
    localparam int N    = 4;
    localparam int P0   = 0;
    localparam int P1   = 0;
    localparam int P2   = 0;
    localparam int P3   = 7;
    localparam int MAXO = 2;
    localparam int TMO  = 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic srst    = 1'b0;
    always #5 aclk = ~aclk;

    axicb_mst_arbiter_if #(.REQ_NB(N)) arb ();

    axicb_mst_arbiter #(
        .REQ_NB(N), .REQ0_PRIORITY(P0), .REQ1_PRIORITY(P1), .REQ2_PRIORITY(P2),
        .REQ3_PRIORITY(P3), .MAX_OUTSTANDING(MAXO), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .arb(arb.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: which master holds the grant (-1 = none), counts, pointer, timer.
    typedef struct packed {
        logic [3:0]  grant;
        logic        busy;
        logic [15:0] cnt;
        logic        pulse;
        logic [1:0]  idx;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   m_g, m_ptr, m_tmr, m_idx;
    int   m_cnt[4];
    bit   m_err, m_pulse;

    function automatic int lvl(input int i);
        int p;
        case (i)
            0: p = P0;
            1: p = P1;
            2: p = P2;
            default: p = P3;
        endcase
        return (p > 3) ? 3 : p;
    endfunction

    task automatic model_reset();
        m_g = -1; m_ptr = N - 1; m_tmr = 0; m_idx = 0; m_err = 0; m_pulse = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic a, input logic [3:0] d);
        int g_old;
        int c_old[4];
        int best, bl, i;
        bit inc;
        g_old   = m_g;
        c_old   = m_cnt;
        m_pulse = 0;
        if (g_old < 0) begin
            best = -1; bl = -1;
            for (int k = 1; k <= N; k++) begin
                i = (m_ptr + k) % N;
                if (r[i] && c_old[i] < MAXO && lvl(i) > bl) begin
                    best = i; bl = lvl(i);
                end
            end
            if (best >= 0) begin m_g = best; m_tmr = 0; end
        end else if (a) begin
            m_ptr = g_old; m_g = -1;
        end else if (!r[g_old]) begin
            m_g = -1;
        end else if (m_tmr == TMO - 1) begin
            m_pulse = 1; m_idx = g_old; m_ptr = g_old; m_g = -1;
        end else begin
            m_tmr++;
        end
        for (int k = 0; k < 4; k++) begin
            inc = (g_old == k) && a && (c_old[k] < MAXO);
            if (inc && !d[k]) m_cnt[k] = c_old[k] + 1;
            else if (d[k] && !inc) begin
                if (c_old[k] == 0) m_err = 1;
                else               m_cnt[k] = c_old[k] - 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.grant = (m_g >= 0) ? 4'(1 << m_g) : 4'd0;
        e.busy  = (m_g >= 0);
        e.cnt   = {4'(m_cnt[3]), 4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
        e.pulse = m_pulse;
        e.idx   = 2'(m_idx);
        e.err   = m_err;
        return e;
    endfunction

    always @(posedge aclk) begin
        if (!aresetn || srst) model_reset();
        else model_step(arb.req, arb.accept, arb.done);
        sb.push_back(model_out());
    end

    always begin
        exp_t e;
        @(posedge aclk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = sb.pop_front();
            chk("sb_grant", arb.grant, e.grant);
            chk("sb_busy", arb.busy, e.busy);
            chk("sb_out_cnt", arb.out_cnt, e.cnt);
            chk("sb_timeout_pulse", arb.timeout_pulse, e.pulse);
            chk("sb_cnt_err", arb.cnt_err, e.err);
            if (e.pulse) chk("sb_timeout_idx", arb.timeout_idx, e.idx);
        end
    end

    task automatic drive(input logic [3:0] r, input logic a, input logic [3:0] d);
        @(negedge aclk);
        arb.req = r; arb.accept = a; arb.done = d;
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic do_srst();
        @(negedge aclk);
        srst = 1'b1; arb.req = '0; arb.accept = 1'b0; arb.done = '0;
        @(negedge aclk);
        srst = 1'b0;
    endtask

    int rr_exp[8]   = '{1, 0, 2, 0, 4, 0, 1, 0};
    int prio_exp[8] = '{8, 0, 8, 0, 1, 0, 2, 0};
    int lim_exp[6]  = '{1, 0, 1, 0, 0, 0};
    logic [3:0] rq;
    int acc_pct;

    initial begin
        arb.req = '0; arb.accept = 1'b0; arb.done = '0;
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_grant", arb.grant, 0);
        chk("rst_busy", arb.busy, 0);
        chk("rst_out_cnt", arb.out_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // asynchronous reset while master 1 holds the grant
        drive(4'b0010, 1'b0, 4'b0000);
        tick();
        chk("mid_grant_pre", arb.grant, 4'b0010);
        @(negedge aclk);
        #1;
        aresetn = 1'b0; arb.req = '0;
        #1;
        chk("async_rst_grant", arb.grant, 0);
        chk("async_rst_busy", arb.busy, 0);
        chk("async_rst_out_cnt", arb.out_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick(); tick();
        chk("post_rst_idle", arb.grant, 0);

        // round robin among equal levels
        drive(4'b0111, 1'b1, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_grant", arb.grant, rr_exp[k]);
        end
        do_srst();

        // master 3 wins on level until its limit, then the others rotate
        drive(4'b1111, 1'b1, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("prio_grant", arb.grant, prio_exp[k]);
        end
        chk("prio_out_cnt", arb.out_cnt, 16'h2011);
        do_srst();

        // outstanding limit, then release by done
        drive(4'b0001, 1'b1, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("limit_grant", arb.grant, lim_exp[k]);
        end
        chk("limit_cnt0", arb.out_cnt[3:0], 2);
        drive(4'b0001, 1'b1, 4'b0001);
        tick();
        chk("limit_done_cnt0", arb.out_cnt[3:0], 1);
        chk("limit_done_grant", arb.grant, 0);
        drive(4'b0001, 1'b1, 4'b0000);
        tick();
        chk("limit_regrant", arb.grant, 4'b0001);
        do_srst();

        // stalled grant is revoked after TMO cycles
        drive(4'b0011, 1'b0, 4'b0000);
        for (int k = 0; k < TMO; k++) begin
            tick();
            chk("tmo_hold", arb.grant, 4'b0001);
        end
        tick();
        chk("tmo_grant_drop", arb.grant, 0);
        chk("tmo_pulse", arb.timeout_pulse, 1);
        chk("tmo_idx", arb.timeout_idx, 0);
        tick();
        chk("tmo_next_grant", arb.grant, 4'b0010);
        chk("tmo_pulse_clear", arb.timeout_pulse, 0);
        do_srst();

        // same-cycle accept/done, and done on an empty count
        drive(4'b0010, 1'b1, 4'b0000);
        tick(); tick();
        chk("bnd_cnt1_first", arb.out_cnt, 16'h0010);
        tick();
        chk("bnd_regrant", arb.grant, 4'b0010);
        drive(4'b0010, 1'b1, 4'b0010);
        tick();
        chk("bnd_acc_done_cnt", arb.out_cnt, 16'h0010);
        chk("bnd_err_before", arb.cnt_err, 0);
        drive(4'b0000, 1'b0, 4'b1000);
        tick();
        chk("bnd_err_set", arb.cnt_err, 1);
        chk("bnd_cnt3_zero", arb.out_cnt, 16'h0010);
        drive(4'b0000, 1'b0, 4'b0000);
        tick();
        chk("bnd_err_sticky", arb.cnt_err, 1);
        do_srst();
        tick();
        chk("srst_err_clear", arb.cnt_err, 0);

        // randomized traffic with sticky requests
        rq = 4'b0000;
        acc_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(3))
                    0: acc_pct = 0;
                    1: acc_pct = 10;
                    2: acc_pct = 40;
                    default: acc_pct = 80;
                endcase
            end
            @(negedge aclk);
            for (int b = 0; b < 4; b++) if ($urandom_range(9) == 0) rq[b] = ~rq[b];
            arb.req    = rq;
            arb.accept = ($urandom_range(99) < acc_pct);
            for (int b = 0; b < 4; b++) arb.done[b] = ($urandom_range(5) == 0);
            srst = ($urandom_range(399) == 0);
        end
        drive(4'b0000, 1'b0, 4'b0000);
        srst = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
